// File: rtl/sr_ff_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sr_ff_cmd_ctrl
// Description : Command sequencer driving the s/r inputs of a downstream SR
//               flip-flop. Accepts hold/clear/set/toggle commands over a
//               valid/ready handshake, pulses s or r for PULSE_LEN cycles,
//               releases for one cycle, then checks the flip-flop readback
//               and retries a bounded number of times before flagging err.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_ff_cmd_ctrl #(
  parameter int PULSE_LEN = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  input  logic       q_in,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Out-of-range parameters are clamped so the counters can never run away.
  localparam int PULSE_EFF = (PULSE_LEN < 1) ? 1 : ((PULSE_LEN > 15) ? 15 : PULSE_LEN);
  localparam int RETRY_EFF = (MAX_RETRY < 0) ? 0 : ((MAX_RETRY > 7) ? 7 : MAX_RETRY);

  localparam logic [3:0] C_PULSE_LAST = 4'(PULSE_EFF - 1);
  localparam logic [2:0] C_RETRY_MAX  = 3'(RETRY_EFF);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] retry_q, retry_d;
  logic       target_q, target_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       drive_d;
  logic       accept;

  // Ready only while idle and never while reset is asserted.
  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

  // Next-state logic; drive_d selects whether the pulse is active next cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    target_d = target_q;
    drive_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_HOLD) begin
            done_d = 1'b1;
          end else begin
            if (cmd_op == OP_SET) begin
              target_d = 1'b1;
            end else if (cmd_op == OP_CLEAR) begin
              target_d = 1'b0;
            end else begin
              target_d = ~q_in;
            end
            state_d = ST_DRIVE;
            cnt_d   = 4'd0;
            retry_d = 3'd0;
            drive_d = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q >= C_PULSE_LAST) begin
          state_d = ST_RELEASE;
        end else begin
          cnt_d   = 4'(cnt_q + 4'd1);
          drive_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (q_in == target_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (retry_q < C_RETRY_MAX) begin
          retry_d = 3'(retry_q + 3'd1);
          state_d = ST_DRIVE;
          cnt_d   = 4'd0;
          drive_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // s and r derive from one target bit, so they can never both be high.
    s_d    = drive_d & target_d;
    r_d    = drive_d & ~target_d;
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      retry_q  <= 3'd0;
      target_q <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      target_q <= target_d;
      s_q      <= s_d;
      r_q      <= r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign s    = s_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_ff_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sr_ff_cmd_ctrl
// Description : Self-checking bench for sr_ff_cmd_ctrl with an attached SR
//               flip-flop plant whose readback can be forced stuck.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_ff_cmd_ctrl;

  localparam int P  = 1;
  localparam int MR = 2;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op    = 2'b00;
  logic       cmd_ready;
  logic       q_in;
  logic       s, r, busy, done, err;

  logic q_ff      = 1'b0;
  logic stuck_en  = 1'b0;
  logic stuck_val = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  sr_ff_cmd_ctrl #(.PULSE_LEN(P), .MAX_RETRY(MR)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .q_in      (q_in),
    .s         (s),
    .r         (r),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // SR flip-flop plant; readback may be overridden to emulate a stuck q.
  always @(posedge clk) begin
    if (reset) q_ff <= 1'b0;
    else if (s) q_ff <= 1'b1;
    else if (r) q_ff <= 1'b0;
  end
  assign q_in = stuck_en ? stuck_val : q_ff;

  // Reference model: expected {s,r,busy,done,err} k cycles after acceptance
  // of a drive command with target tgt, att drive attempts, final outcome ok.
  function automatic logic [4:0] exp_vec(int k, logic tgt, int att, logic ok);
    int fin;
    int off;
    fin = 1 + att * (P + 1);
    if (k < 1 || k > fin) return 5'b00000;
    if (k == fin) return {3'b000, ok, ~ok};
    off = (k - 1) % (P + 1);
    if (off < P) return {tgt, ~tgt, 3'b100};
    return 5'b00100;
  endfunction

  function automatic logic op_target(logic [1:0] op, logic qnow);
    if (op == 2'b10) return 1'b1;
    if (op == 2'b01) return 1'b0;
    return ~qnow;
  endfunction

  // Presents one command for a single edge; entered just after a negedge.
  task automatic issue(input logic [1:0] op, output logic tgt);
    tgt       = op_target(op, stuck_en ? stuck_val : q_ff);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_ready cyc%0d: got %b expected 0", c, cmd_ready);
      end
      tests_run++;
      if ({s, r, busy, done, err} !== 5'b00000) begin
        tests_failed++;
        $display("FAIL reset_outputs cyc%0d: got %b expected 00000", c, {s, r, busy, done, err});
      end
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_ready: got %b expected 1", cmd_ready);
    end
    @(negedge clk);
    tests_run++;
    if ({s, r, busy, done, err, cmd_ready} !== 6'b000001) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %b expected 000001", {s, r, busy, done, err, cmd_ready});
    end
  endtask

  task automatic test_set();
    logic tgt;
    logic [4:0] exp;
    issue(2'b10, tgt);
    for (int k = 1; k <= P + 3; k++) begin
      @(negedge clk);
      exp = exp_vec(k, tgt, 1, 1'b1);
      tests_run++;
      if ({s, r, busy, done, err} !== exp) begin
        tests_failed++;
        $display("FAIL set k=%0d: got %b expected %b", k, {s, r, busy, done, err}, exp);
      end
    end
    tests_run++;
    if (q_ff !== 1'b1) begin
      tests_failed++;
      $display("FAIL set_q: got %b expected 1", q_ff);
    end
  endtask

  task automatic test_toggle();
    logic tgt;
    logic [4:0] exp;
    for (int t = 0; t < 2; t++) begin
      issue(2'b11, tgt);
      for (int k = 1; k <= P + 3; k++) begin
        @(negedge clk);
        exp = exp_vec(k, tgt, 1, 1'b1);
        tests_run++;
        if ({s, r, busy, done, err} !== exp) begin
          tests_failed++;
          $display("FAIL toggle%0d k=%0d: got %b expected %b", t, k, {s, r, busy, done, err}, exp);
        end
      end
      tests_run++;
      if (q_ff !== ((t == 0) ? 1'b0 : 1'b1)) begin
        tests_failed++;
        $display("FAIL toggle%0d_q: got %b expected %b", t, q_ff, (t == 0) ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic test_retry_err();
    logic tgt;
    logic [4:0] exp;
    stuck_en  = 1'b1;
    stuck_val = 1'b0;
    issue(2'b10, tgt);
    for (int k = 1; k <= 1 + (MR + 1) * (P + 1) + 1; k++) begin
      @(negedge clk);
      exp = exp_vec(k, tgt, MR + 1, 1'b0);
      tests_run++;
      if ({s, r, busy, done, err} !== exp) begin
        tests_failed++;
        $display("FAIL retry_err k=%0d: got %b expected %b", k, {s, r, busy, done, err}, exp);
      end
    end
    stuck_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic tgt;
    issue(2'b10, tgt);
    @(negedge clk);
    tests_run++;
    if (s !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_drive_s: got %b expected 1", s);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({s, r, busy, done, err, cmd_ready} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got %b expected 000000", {s, r, busy, done, err, cmd_ready});
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_ready: got %b expected 1", cmd_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if ({s, r, busy, done, err} !== 5'b00000) begin
        tests_failed++;
        $display("FAIL mid_reset_quiet k=%0d: got %b expected 00000", k, {s, r, busy, done, err});
      end
    end
  endtask

  // cmd_valid held high; every accepted command is tracked to completion,
  // including back-to-back acceptance in the done/err cycle.
  task automatic test_random();
    int         accepted = 0;
    int         cycles   = 0;
    int         k        = 0;
    int         att      = 0;
    int         fin      = 0;
    logic       active   = 1'b0;
    logic       hold     = 1'b0;
    logic       tgt      = 1'b0;
    logic       ok       = 1'b1;
    logic [1:0] op;
    logic [4:0] exp;
    cmd_valid = 1'b1;
    while ((accepted < 500 || active) && cycles < 20000) begin
      if (!active && accepted < 500) begin
        tests_run++;
        if (cmd_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL rand_ready_idle cyc%0d: got %b expected 1", cycles, cmd_ready);
        end
        stuck_en  = ($urandom_range(0, 9) == 0);
        stuck_val = 1'($urandom_range(0, 1));
        op        = 2'($urandom_range(0, 3));
        cmd_op    = op;
        hold      = (op == 2'b00);
        tgt       = op_target(op, stuck_en ? stuck_val : q_ff);
        ok        = !(stuck_en && stuck_val != tgt);
        att       = hold ? 0 : (ok ? 1 : MR + 1);
        fin       = hold ? 1 : 1 + att * (P + 1);
        accepted++;
        active    = 1'b1;
        k         = 0;
      end else begin
        if (accepted >= 500) cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        tests_run++;
        if (cmd_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand_ready_busy cyc%0d: got %b expected 0", cycles, cmd_ready);
        end
      end
      @(negedge clk);
      cycles++;
      k++;
      exp = hold ? ((k == 1) ? 5'b00010 : 5'b00000) : exp_vec(k, tgt, att, ok);
      tests_run++;
      if ({s, r, busy, done, err} !== exp) begin
        tests_failed++;
        $display("FAIL rand cmd%0d op=%b k=%0d: got %b expected %b", accepted, op, k, {s, r, busy, done, err}, exp);
      end
      tests_run++;
      if ((s & r) !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_s_and_r cyc%0d: got %b expected 0", cycles, s & r);
      end
      if (k == fin) active = 1'b0;
    end
    cmd_valid = 1'b0;
    stuck_en  = 1'b0;
    tests_run++;
    if (cycles >= 20000) begin
      tests_failed++;
      $display("FAIL rand_budget: got %0d commands expected 500 within budget", accepted);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_toggle();
    test_retry_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
